// File: rtl/frequency_gate_counter.sv
// Gated rising-edge counter with an auto-ranging feedback loop to the range prescaler.
// Optional manual range override is enabled by FREQUENCY_GATE_COUNTER_MANUAL_RANGE_EN.
module frequency_gate_counter #(
    parameter int unsigned GATE_CYCLES   = 50000000,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned HIGH_THRESH   = 1000000,
    parameter int unsigned LOW_THRESH    = 90000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signalIn,
    input  logic                 highFrequency,
`ifdef FREQUENCY_GATE_COUNTER_MANUAL_RANGE_EN
    input  logic                 rangeLock,
    input  logic                 manualRange,
`endif
    output logic                 frequencyControl,
    output logic [CNT_WIDTH-1:0] frequency,
    output logic                 valid,
    output logic                 overflow
);

    localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int unsigned PROD_W  = CNT_WIDTH + 4;
    localparam int unsigned CMP_W   = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_GATE   = 2'd1,
        ST_EVAL   = 2'd2
    } state_t;

    state_t                 state;
    logic [TMR_W-1:0]       timer;
    logic [CNT_WIDTH-1:0]   edge_cnt;
    logic                   sat;
    logic                   sig_meta, sig_sync, sig_last;
    logic                   hf_meta, hf_sync;

    logic                   pulse_c;
    logic [PROD_W-1:0]      prod_c;
    logic                   prod_sat_c;
    logic [CNT_WIDTH-1:0]   prod_clip_c;
    logic                   above_high_c;
    logic                   below_low_c;
    logic                   lock_c;
    logic                   manual_change_c;

    // Two-flop synchronizers plus a history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_meta <= 1'b0;
            sig_sync <= 1'b0;
            sig_last <= 1'b0;
            hf_meta  <= 1'b0;
            hf_sync  <= 1'b0;
        end else begin
            sig_meta <= signalIn;
            sig_sync <= sig_meta;
            sig_last <= sig_sync;
            hf_meta  <= highFrequency;
            hf_sync  <= hf_meta;
        end
    end

    assign pulse_c      = sig_sync & ~sig_last;
    assign prod_c       = PROD_W'(edge_cnt) * PROD_W'(10);
    assign prod_sat_c   = |prod_c[PROD_W-1:CNT_WIDTH];
    assign prod_clip_c  = prod_sat_c ? {CNT_WIDTH{1'b1}} : prod_c[CNT_WIDTH-1:0];
    assign above_high_c = CMP_W'(edge_cnt) > CMP_W'(HIGH_THRESH);
    assign below_low_c  = CMP_W'(edge_cnt) < CMP_W'(LOW_THRESH);

`ifdef FREQUENCY_GATE_COUNTER_MANUAL_RANGE_EN
    assign lock_c          = rangeLock;
    assign manual_change_c = rangeLock & (manualRange != frequencyControl);
`else
    assign lock_c          = 1'b0;
    assign manual_change_c = 1'b0;
`endif

    // Settle / gate / evaluate sequencer with registered result and range request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_SETTLE;
            timer            <= '0;
            edge_cnt         <= '0;
            sat              <= 1'b0;
            frequencyControl <= 1'b0;
            frequency        <= '0;
            valid            <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (manual_change_c) begin
                frequencyControl <= ~frequencyControl;
                state            <= ST_SETTLE;
                timer            <= '0;
            end else begin
                unique case (state)
                    ST_SETTLE: begin
                        if (timer == TMR_W'(SETTLE_CYCLES - 1)) begin
                            state    <= ST_GATE;
                            timer    <= '0;
                            edge_cnt <= '0;
                            sat      <= 1'b0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    ST_GATE: begin
                        // Saturating count; an edge lost at all-ones marks the result.
                        if (pulse_c) begin
                            if (&edge_cnt) sat <= 1'b1;
                            else           edge_cnt <= edge_cnt + CNT_WIDTH'(1);
                        end
                        if (timer == TMR_W'(GATE_CYCLES - 1)) begin
                            state <= ST_EVAL;
                            timer <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    ST_EVAL: begin
                        if (hf_sync != frequencyControl) begin
                            state <= ST_SETTLE;
                        end else if (!frequencyControl && above_high_c && !lock_c) begin
                            frequencyControl <= 1'b1;
                            state            <= ST_SETTLE;
                        end else if (frequencyControl && below_low_c && !lock_c) begin
                            frequencyControl <= 1'b0;
                            state            <= ST_SETTLE;
                        end else begin
                            state     <= ST_GATE;
                            edge_cnt  <= '0;
                            sat       <= 1'b0;
                            valid     <= 1'b1;
                            frequency <= frequencyControl ? prod_clip_c : edge_cnt;
                            overflow  <= sat | (frequencyControl & prod_sat_c);
                        end
                    end
                    default: begin
                        state <= ST_SETTLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frequency_gate_counter.sv
// Self-checking bench for frequency_gate_counter with a prescaler model and a window-count reference.
module tb_frequency_gate_counter;

    localparam int LOG_N = 65536;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        signal_in = 1'b0;
    logic        high_frequency = 1'b0;
    logic        frequency_control;
    logic [31:0] frequency;
    logic        valid;
    logic        overflow;

    logic        signal_in2 = 1'b0;
    logic        high_frequency2 = 1'b0;
    logic        frequency_control2;
    logic [7:0]  frequency2;
    logic        valid2;
    logic        overflow2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rst = 0;
    bit pin_log [0:LOG_N-1];
    bit done2 = 1'b0;

    int   period = 10;
    int   ph = 0;
    int   div_cnt = 0;
    bit   base = 1'b0, base_q = 1'b0, div_out = 1'b0;
    bit   rand_mode = 1'b0, force_hf = 1'b0;
    logic [1:0] hf_pipe = 2'b00;
    logic [1:0] hf2_pipe = 2'b00;

    frequency_gate_counter #(
        .GATE_CYCLES(1000), .SETTLE_CYCLES(8), .CNT_WIDTH(32),
        .HIGH_THRESH(200), .LOW_THRESH(15)
    ) dut (
        .clk(clk), .reset(reset), .signalIn(signal_in), .highFrequency(high_frequency),
        .frequencyControl(frequency_control), .frequency(frequency),
        .valid(valid), .overflow(overflow)
    );

    frequency_gate_counter #(
        .GATE_CYCLES(1000), .SETTLE_CYCLES(8), .CNT_WIDTH(8),
        .HIGH_THRESH(1000), .LOW_THRESH(15)
    ) dut8 (
        .clk(clk), .reset(reset), .signalIn(signal_in2), .highFrequency(high_frequency2),
        .frequencyControl(frequency_control2), .frequency(frequency2),
        .valid(valid2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    // Pin history per clock edge, used by the window-count reference.
    always @(posedge clk) begin
        if (cyc < LOG_N) pin_log[cyc] = signal_in;
        if (reset) last_rst = cyc;
        cyc = cyc + 1;
    end

    // Prescaler model: range flag trails the request by 2 clk, divides the signal by 10 when high.
    always @(negedge clk) begin
        hf_pipe        = {hf_pipe[0], frequency_control};
        high_frequency = force_hf | hf_pipe[1];
        if (rand_mode) begin
            if ($urandom_range(0, 9) == 0) base = ~base;
        end else begin
            ph   = (ph + 1 >= period) ? 0 : ph + 1;
            base = (ph < period / 2);
        end
        if (base && !base_q) begin
            div_cnt = (div_cnt == 4) ? 0 : div_cnt + 1;
            if (div_cnt == 0) div_out = ~div_out;
        end
        base_q    = base;
        signal_in = hf_pipe[1] ? div_out : base;

        hf2_pipe        = {hf2_pipe[0], frequency_control2};
        high_frequency2 = hf2_pipe[1];
        signal_in2      = ~signal_in2;
    end

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wait_valid(input int budget, output bit seen, output int idx);
        seen = 1'b0;
        idx  = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1'b1;
                idx  = cyc - 1;
            end
        end
    endtask

    task automatic expect_quiet(input string name, input int n);
        int hits = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (valid) hits++;
        end
        check(name, hits, 0);
    endtask

    // Rising edges counted by a gate whose counter updates on edges first..last (3-clk pin latency).
    function automatic int model_count(input int first, input int last);
        int n = 0;
        for (int e = first; e <= last; e++)
            if (pin_log[e-2] && !pin_log[e-3]) n++;
        return n;
    endfunction

    typedef struct {
        int period;
        int skip;
        int exp_freq;
        int exp_fc;
        int exp_ovf;
        int exp_gap;
    } vec_t;

    initial begin
        vec_t tbl [6];
        bit   seen;
        int   idx, prev, cnt;

        tbl[0] = '{period: 10,   skip: 0, exp_freq: 100, exp_fc: 0, exp_ovf: 0, exp_gap: 1009};
        tbl[1] = '{period: 10,   skip: 0, exp_freq: 100, exp_fc: 0, exp_ovf: 0, exp_gap: 1001};
        tbl[2] = '{period: 4,    skip: 0, exp_freq: 250, exp_fc: 1, exp_ovf: 0, exp_gap: 2010};
        tbl[3] = '{period: 4,    skip: 0, exp_freq: 250, exp_fc: 1, exp_ovf: 0, exp_gap: 1001};
        tbl[4] = '{period: 1000, skip: 0, exp_freq: 1,   exp_fc: 0, exp_ovf: 0, exp_gap: 2010};
        tbl[5] = '{period: 10,   skip: 1, exp_freq: 100, exp_fc: 0, exp_ovf: 0, exp_gap: 1001};

        repeat (3) @(negedge clk);
        check("reset_frequency", frequency, 0);
        check("reset_valid", valid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_fc", frequency_control, 0);
        check("reset_frequency8", frequency2, 0);
        check("reset_valid8", valid2, 0);
        reset = 1'b0;
        prev  = last_rst;

        // Table-driven range sequence: low range, up-range, down-range, back to steady.
        foreach (tbl[i]) begin
            if (tbl[i].period != period) begin
                period = tbl[i].period;
                ph     = 0;
            end
            for (int s = 0; s < tbl[i].skip; s++) begin
                wait_valid(2200, seen, idx);
                check($sformatf("vec%0d_skip_seen", i), seen, 1);
                prev = idx;
            end
            wait_valid(2200, seen, idx);
            check($sformatf("vec%0d_valid_seen", i), seen, 1);
            check($sformatf("vec%0d_frequency", i), frequency, tbl[i].exp_freq);
            check($sformatf("vec%0d_fc", i), frequency_control, tbl[i].exp_fc);
            check($sformatf("vec%0d_overflow", i), overflow, tbl[i].exp_ovf);
            check($sformatf("vec%0d_gap", i), idx - prev, tbl[i].exp_gap);
            prev = idx;
        end

        // Range flag disagreeing with the request suppresses every result.
        force_hf = 1'b1;
        expect_quiet("forced_hf_no_valid", 6000);
        check("forced_hf_fc", frequency_control, 0);
        force_hf = 1'b0;
        wait_valid(2100, seen, idx);
        check("restored_valid_seen", seen, 1);
        check("restored_frequency", frequency, 100);
        prev = idx;

        // Reset half-way through a gate discards it and restarts the settle/gate sequence.
        expect_quiet("pre_reset_quiet", 500);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_frequency", frequency, 0);
        check("midreset_valid", valid, 0);
        check("midreset_overflow", overflow, 0);
        check("midreset_fc", frequency_control, 0);
        reset = 1'b0;
        wait_valid(1200, seen, idx);
        check("postreset_valid_seen", seen, 1);
        check("postreset_gap", idx - last_rst, 1009);
        check("postreset_frequency", frequency, 100);
        prev = idx;

        // Random pin activity against the window-count reference.
        rand_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_valid(1100, seen, idx);
            check($sformatf("rand%0d_valid_seen", k), seen, 1);
            check($sformatf("rand%0d_gap", k), idx - prev, 1001);
            cnt = model_count(prev + 1, prev + 1000);
            check($sformatf("rand%0d_frequency", k), frequency, cnt);
            check($sformatf("rand%0d_overflow", k), overflow, 0);
            prev = idx;
        end

        wait (done2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Narrow counter: 500 edges per gate saturate an 8-bit count.
    initial begin
        bit s;
        wait (reset == 1'b0);
        for (int k = 0; k < 2; k++) begin
            s = 1'b0;
            for (int n = 0; n < 1200 && !s; n++) begin
                @(negedge clk);
                if (valid2) s = 1'b1;
            end
            check($sformatf("cnt8_%0d_valid_seen", k), s, 1);
            check($sformatf("cnt8_%0d_frequency", k), frequency2, 255);
            check($sformatf("cnt8_%0d_overflow", k), overflow2, 1);
            check($sformatf("cnt8_%0d_fc", k), frequency_control2, 0);
        end
        done2 = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
